// File: rtl/fma_special_pipe.sv
// Two-stage special-case/exception stage after the FMA round datapath.
// Ports: x,y,z,sum,nonzero_mant,rm in (valid/ready); result,special,flags out; fflags accrued.
module fma_special_pipe #(
  parameter int EW = 5,
  parameter int MW = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x,
  input  logic [EW+MW:0]   y,
  input  logic [EW+MW:0]   z,
  input  logic [EW+MW:0]   sum,
  input  logic             nonzero_mant,
  input  logic [2:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   result,
  output logic             special,
  output logic [4:0]       flags,
  output logic [4:0]       fflags,
  input  logic             fflags_clr
);

  localparam int FLEN = 1 + EW + MW;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;

  localparam logic [FLEN-1:0] QNAN =
    {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  // {zero, inf, qnan, snan}
  function automatic logic [3:0] classify(
    input logic [FLEN-1:0] v
  );
    logic eo, ez, mz;
    eo = &v[MW+:EW];
    ez = ~|v[MW+:EW];
    mz = ~|v[MW-1:0];
    classify = {ez & mz, eo & mz,
                eo & v[MW-1],
                eo & ~v[MW-1] & ~mz};
  endfunction

  logic            s1_valid;
  logic [FLEN-1:0] s1_x, s1_y, s1_z, s1_sum;
  logic            s1_nm;
  logic [2:0]      s1_rm;

  logic s2_adv;
  logic hs;

  assign s2_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_adv;
  assign hs       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_z     <= '0;
      s1_sum   <= '0;
      s1_nm    <= 1'b0;
      s1_rm    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x   <= x;
        s1_y   <= y;
        s1_z   <= z;
        s1_sum <= sum;
        s1_nm  <= nonzero_mant;
        s1_rm  <= rm;
      end
    end
  end

  logic [3:0] cx, cy, cz;
  logic xs, ys, zs, ps;
  logic any_nan, any_snan;
  logic p_inf, p_zero, inv;
  logic sum_eo, sum_ez, ss, to_inf;

  assign cx = classify(s1_x);
  assign cy = classify(s1_y);
  assign cz = classify(s1_z);
  assign xs = s1_x[FLEN-1];
  assign ys = s1_y[FLEN-1];
  assign zs = s1_z[FLEN-1];
  assign ps = xs ^ ys;

  assign any_nan  = |{cx[1:0], cy[1:0], cz[1:0]};
  assign any_snan = cx[0] | cy[0] | cz[0];
  assign p_inf    = cx[2] | cy[2];
  assign p_zero   = cx[3] | cy[3];
  assign inv      = (p_inf & p_zero)
                  | (p_inf & cz[2] & (zs != ps));

  assign sum_eo = &s1_sum[MW+:EW];
  assign sum_ez = ~|s1_sum[MW+:EW];
  assign ss     = s1_sum[FLEN-1];
  // Overflow rounds to infinity unless the mode pulls toward zero.
  assign to_inf = (s1_rm == RNE) | (s1_rm == RMM)
                | ((s1_rm == RUP) & ~ss)
                | ((s1_rm == RDN) & ss);

  logic [FLEN-1:0] nx_res;
  logic            nx_spec;
  logic [4:0]      nx_flags;

  always_comb begin
    nx_res   = s1_sum;
    nx_spec  = 1'b0;
    nx_flags = {4'b0000, s1_nm};
    if (any_nan) begin
      nx_res   = QNAN;
      nx_spec  = 1'b1;
      nx_flags = {any_snan, 4'b0000};
    end else if (inv) begin
      nx_res   = QNAN;
      nx_spec  = 1'b1;
      nx_flags = 5'b10000;
    end else if (p_inf) begin
      nx_res   = {ps, {EW{1'b1}}, {MW{1'b0}}};
      nx_spec  = 1'b1;
      nx_flags = '0;
    end else if (cz[2]) begin
      nx_res   = s1_z;
      nx_spec  = 1'b1;
      nx_flags = '0;
    end else if (p_zero & cz[3]) begin
      nx_res   = '0;
      nx_res[FLEN-1] = (zs == ps) ? ps
                     : (s1_rm == RDN);
      nx_spec  = 1'b1;
      nx_flags = '0;
    end else if (p_zero) begin
      nx_res   = s1_z;
      nx_spec  = 1'b1;
      nx_flags = '0;
    end else if (sum_eo) begin
      nx_res   = to_inf
               ? {ss, {EW{1'b1}}, {MW{1'b0}}}
               : {ss, {(EW-1){1'b1}}, 1'b0,
                  {MW{1'b1}}};
      nx_flags = 5'b00101;
    end else if (sum_ez & s1_nm) begin
      nx_flags = 5'b00011;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      special   <= 1'b0;
      flags     <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= nx_res;
        special <= nx_spec;
        flags   <= nx_flags;
      end
    end
  end

  // Clear wins over history but still keeps a same-cycle delivery.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fflags <= '0;
    end else if (fflags_clr) begin
      fflags <= hs ? flags : 5'b00000;
    end else if (hs) begin
      fflags <= fflags | flags;
    end
  end

endmodule

// File: tb/tb_fma_special_pipe.sv
// Scoreboard bench for fma_special_pipe (half precision).
// Directed vectors, backpressure, reset and random traffic.
module tb_fma_special_pipe;

  logic        clk = 0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y, z, sum;
  logic        nonzero_mant;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        special;
  logic [4:0]  flags;
  logic [4:0]  fflags;
  logic        fflags_clr;

  int total = 0;
  int bad = 0;
  logic [21:0] q[$];
  logic [4:0]  fexp = 0;
  bit rbp = 0;

  always #5 clk = ~clk;

  fma_special_pipe dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .sum(sum),
    .nonzero_mant(nonzero_mant), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .special(special),
    .flags(flags), .fflags(fflags),
    .fflags_clr(fflags_clr)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  typedef enum {K_ZERO, K_FIN, K_INF, K_QNAN, K_SNAN} kind_t;

  function automatic kind_t kind(input logic [15:0] v);
    if (v[14:10] == 5'd31)
      return (v[9:0] == 0) ? K_INF
           : (v[9] ? K_QNAN : K_SNAN);
    return (v[14:0] == 0) ? K_ZERO : K_FIN;
  endfunction

  // Expected {special, flags, result}
  function automatic logic [21:0] model(
    input logic [15:0] a, b, c, s,
    input logic n, input logic [2:0] r);
    kind_t ka, kb, kc;
    logic ps, sg, toward;
    ka = kind(a); kb = kind(b); kc = kind(c);
    ps = a[15] ^ b[15];
    if (ka == K_SNAN || kb == K_SNAN || kc == K_SNAN)
      return {1'b1, 5'h10, 16'h7E00};
    if (ka == K_QNAN || kb == K_QNAN || kc == K_QNAN)
      return {1'b1, 5'h00, 16'h7E00};
    if ((ka == K_INF || kb == K_INF) &&
        (ka == K_ZERO || kb == K_ZERO))
      return {1'b1, 5'h10, 16'h7E00};
    if ((ka == K_INF || kb == K_INF) &&
        kc == K_INF && c[15] != ps)
      return {1'b1, 5'h10, 16'h7E00};
    if (ka == K_INF || kb == K_INF)
      return {1'b1, 5'h00, ps, 15'h7C00};
    if (kc == K_INF)
      return {1'b1, 5'h00, c};
    if (ka == K_ZERO || kb == K_ZERO) begin
      if (kc != K_ZERO) return {1'b1, 5'h00, c};
      sg = (c[15] == ps) ? ps : (r == 3'd2);
      return {1'b1, 5'h00, sg, 15'h0000};
    end
    if (s[14:10] == 5'd31) begin
      sg = s[15];
      toward = (r == 3'd1) || (r == 3'd3 && sg)
            || (r == 3'd2 && !sg);
      return {1'b0, 5'h05, sg,
              toward ? 15'h7BFF : 15'h7C00};
    end
    if (s[14:10] == 0 && n)
      return {1'b0, 5'h03, s};
    return {1'b0, 4'h0, n, s};
  endfunction

  task automatic send(input logic [15:0] a, b, c, s,
                      input logic n, input logic [2:0] r,
                      input logic [21:0] e);
    bit acc;
    acc = 0;
    in_valid = 1; x = a; y = b; z = c; sum = s;
    nonzero_mant = n; rm = r;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (acc) q.push_back(e);
    else chk("accept_timeout", 0, 1);
  endtask

  task automatic sendm(input logic [15:0] a, b, c, s,
                       input logic n, input logic [2:0] r);
    send(a, b, c, s, n, r, model(a, b, c, s, n, r));
  endtask

  function automatic logic [15:0] rop();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom % 6)
      0: v[14:0] = 0;
      1: v[14:0] = 15'h7C00;
      2: v[14:9] = 6'h3F;
      3: begin
        v[14:9] = 6'h3E;
        if (v[8:0] == 0) v[0] = 1;
      end
      default: begin
        if (v[14:10] == 5'd31) v[14:10] = 5'd30;
        if (v[14:0] == 0) v[0] = 1;
      end
    endcase
    return v;
  endfunction

  // Monitor: scoreboard pop, hold-stable and fflags checks.
  bit held = 0;
  logic [21:0] hv;
  always @(negedge clk) begin
    logic [21:0] e;
    if (!reset_n) begin
      held = 0;
    end else begin
      chk("fflags", {27'd0, fflags}, {27'd0, fexp});
      if (held && out_valid)
        chk("hold", {special, flags, result}, hv);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
          e = {special, flags, result};
        end else begin
          e = q.pop_front();
          chk("result", result, e[15:0]);
          chk("flags", flags, e[20:16]);
          chk("special", special, e[21]);
        end
        fexp = fflags_clr ? e[20:16] : (fexp | e[20:16]);
      end else if (fflags_clr) begin
        fexp = 0;
      end
      held = out_valid && !out_ready;
      hv = {special, flags, result};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rbp) begin
        out_ready  = ($urandom % 4) != 0;
        fflags_clr = ($urandom % 16) == 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset_n = 0; in_valid = 0; x = 0; y = 0; z = 0;
    sum = 0; nonzero_mant = 0; rm = 0;
    out_ready = 1; fflags_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {special, flags}, 0);
    reset_n = 1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fflags", fflags, 0);

    send(16'h0000, 16'h7C00, 16'h3C00, 0, 0, 0,
         {1'b1, 5'h10, 16'h7E00});
    send(16'h7C00, 16'h3C00, 16'hFC00, 0, 0, 0,
         {1'b1, 5'h10, 16'h7E00});
    send(16'h7D00, 16'h3C00, 16'h3C00, 0, 0, 0,
         {1'b1, 5'h10, 16'h7E00});
    send(16'h7E01, 16'h3C00, 16'h3C00, 0, 0, 0,
         {1'b1, 5'h00, 16'h7E00});
    send(16'h3C00, 16'h3C00, 16'h7E00, 0, 0, 0,
         {1'b1, 5'h00, 16'h7E00});
    send(16'h7BFF, 16'h4000, 0, 16'h7C00, 1, 0,
         {1'b0, 5'h05, 16'h7C00});
    send(16'h7BFF, 16'h4000, 0, 16'h7C00, 1, 1,
         {1'b0, 5'h05, 16'h7BFF});
    send(16'hFBFF, 16'h4000, 0, 16'hFC00, 1, 3,
         {1'b0, 5'h05, 16'hFBFF});
    send(16'h8000, 16'h3C00, 16'h0000, 0, 0, 0,
         {1'b1, 5'h00, 16'h0000});
    send(16'h8000, 16'h3C00, 16'h0000, 0, 0, 2,
         {1'b1, 5'h00, 16'h8000});
    send(16'h8000, 16'h3C00, 16'h8000, 0, 0, 0,
         {1'b1, 5'h00, 16'h8000});
    send(16'h3C00, 16'h0400, 16'h0000, 16'h0001, 1, 0,
         {1'b0, 5'h03, 16'h0001});
    send(16'h3C00, 16'h3C00, 16'h3C00, 16'h4000, 0, 0,
         {1'b0, 5'h00, 16'h4000});
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: three back-to-back, consumer stalled.
    out_ready = 0;
    fork
      begin
        send(16'h7BFF, 16'h4000, 0, 16'h7C00, 1, 0,
             {1'b0, 5'h05, 16'h7C00});
        send(16'h3C00, 16'h0400, 0, 16'h0001, 1, 0,
             {1'b0, 5'h03, 16'h0001});
        send(16'h7D00, 16'h3C00, 0, 0, 0, 0,
             {1'b1, 5'h10, 16'h7E00});
      end
    join_none
    repeat (3) @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1;
    fflags_clr = 1;
    @(posedge clk);
    #1;
    fflags_clr = 0;
    repeat (10) @(posedge clk);
    #1;

    rbp = 1;
    for (int i = 0; i < 300; i++)
      sendm(rop(), rop(), rop(), 16'($urandom),
            1'($urandom), 3'($urandom_range(0, 4)));
    rbp = 0;
    @(posedge clk);
    #2;
    out_ready = 1;
    fflags_clr = 0;
    for (int k = 0; k < 200 && q.size() != 0; k++)
      @(negedge clk);
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;

    // Reset with both stages full.
    out_ready = 0;
    sendm(16'h7D00, 16'h3C00, 0, 0, 0, 0);
    sendm(16'h3C00, 16'h3C00, 0, 16'h0001, 1, 0);
    #2;
    reset_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_fflags", fflags, 0);
    q.delete();
    fexp = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_ready", in_ready, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fma_special_pipe.md
# fma_special_pipe

Parametrised, two-stage pipelined special-case and exception stage for the FMA unit; generalises the half-precision special-case handler to any IEEE-754 binary format and adds rounding-mode-aware overflow/zero handling, underflow detection, valid/ready flow control and an accrued-flags register. It sits after the FMA add/round datapath: it takes operands x, y, z and the rounded datapath result `sum`, and emits the architecturally correct result plus RISC-V-ordered exception flags.

## Interface
- `EW`, default 5: exponent width.
- `MW`, default 10: stored mantissa width; FLEN = 1+EW+MW.
- `clk` input 1: clock; all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input transaction present.
- `in_ready` output 1: stage can accept; transfer when `in_valid & in_ready`.
- `x`, `y`, `z` input FLEN each: multiplicands and addend.
- `sum` input FLEN: rounded datapath result for the same transaction.
- `nonzero_mant` input 1: datapath guard/round/sticky nonzero (inexact).
- `rm` input 3: rounding mode; 000 RNE, 001 RZ, 010 RDN, 011 RUP, 100 RMM.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts; transfer when `out_valid & out_ready`.
- `result` output FLEN: final result.
- `special` output 1: result came from a special case rather than `sum`.
- `flags` output 5: {NV, DZ, OF, UF, NX} for this result; DZ is constant 0.
- `fflags` output 5: accrued flags (sticky OR of all delivered `flags`).
- `fflags_clr` input 1: clear accrued flags.

## Operation
- Stage 1 registers x, y, z, sum, nonzero_mant, rm and classifies each operand: zero, inf, qNaN (exp all ones, mant MSB 1), sNaN (exp all ones, mant MSB 0, mant nonzero), finite. Product sign ps = xs^ys.
- Stage 2 selects, in priority order:
  - Any NaN input: canonical NaN (sign 0, exp all ones, mant MSB only). NV if any sNaN; a qNaN alone raises nothing.
  - Invalid: (zero × inf) or (product inf and z inf with z sign ≠ ps): canonical NaN, NV.
  - Product inf: inf with sign ps, no flags.
  - z inf, product finite: z, no flags.
  - Product exactly zero (x or y zero) and z zero: same signs → that zero; different signs → +0, except −0 when rm=RDN. No flags.
  - Product exactly zero, z nonzero finite: z, no flags.
  - Overflow (`sum` exp all ones, no case above): OF|NX. Result inf with sign of sum for RNE/RMM, RUP positive, RDN negative; otherwise max finite (exp all-ones minus 1, mant all ones) with sign of sum.
  - Underflow (`sum` exp zero and nonzero_mant): result sum, UF|NX.
  - Otherwise result sum, NX = nonzero_mant.
- `special` = 1 for all cases except the last two and overflow.
- `fflags`: on output handshake `fflags <= fflags | flags`. `fflags_clr` alone → 0; clr with handshake in same cycle → `flags` of that transaction.

## Timing
- Latency 2 cycles from input handshake to `out_valid`, no bubbles at full throughput (one transaction per cycle with `out_ready` high).
- Stage 2 advances when empty or `out_ready`; stage 1 advances when stage 2 advances. `in_ready = ~s1_valid | s1_advance`, combinational from `out_ready`.
- `result`, `special`, `flags` registered and held stable while `out_valid & ~out_ready`.
- Two-deep: with `out_ready` low, accepts at most two transactions, then `in_ready` = 0.
- Reset (any time, incl. mid-transaction): valids 0, `result` 0, `special` 0, `flags` 0, `fflags` 0; in-flight transactions dropped; `in_ready` = 1 after reset release.

## Test plan
- x=0x0000, y=0x7C00, z=0x3C00 → result 0x7E00, flags NV (0x10), special=1; x=0x7C00, y=0x3C00, z=0xFC00 → 0x7E00, NV.
- x=0x7D00 (sNaN) → 0x7E00, NV; x=0x7E01 (qNaN) → 0x7E00, flags 0.
- x=0x7BFF, y=0x4000, z=0, sum=0x7C00: rm=RNE → 0x7C00, flags 0x05 (OF|NX); rm=RZ → 0x7BFF, 0x05; sum=0xFC00 with rm=RUP → 0xFBFF.
- x=0x8000, y=0x3C00, z=0x0000: rm=RNE → 0x0000; rm=RDN → 0x8000; sum=0x0001 with nonzero_mant=1, finite nonzero operands → 0x0001, flags 0x03.
- Three back-to-back inputs, `out_ready` low 4 cycles: `in_ready` drops after second accept, outputs delivered in order, held stable; `fflags` ORs only delivered flags; `fflags_clr` with handshake yields that transaction's flags.
- Assert `reset_n` low with both stages full → `out_valid` 0, `fflags` 0 immediately (asynchronously); no stale result after release.
